// File: rtl/scroll_scan_driver.sv
// Purpose : stores a character message, fetches decoder columns for it, scrolls them through a
//           DISP_COLS-wide frame buffer and time-multiplexes that buffer onto an LED matrix.
// Latency : col_sel_n/row_n are registered one cycle after the scan position; c is combinational.
// Backpr. : none; writes are accepted every cycle, and run=0 only freezes scrolling (scan continues).
//
// Ports:
//   clk, reset              clock (rising edge), asynchronous active-high reset
//   run                     1 = scroll enabled, 0 = frame frozen (scanning continues)
//   wr_en/wr_addr/wr_data   message write port, msg[wr_addr] <= wr_data
//   msg_len                 active message length, 0..MSG_MAX
//   c                       character code presented to the decoder
//   col_0..col_5            decoder columns for c, active low (col_5 is the inter-character gap)
//   col_sel_n/row_n         one-hot-low column enable and active-low row data for the matrix
//   frame_done/scroll_step  one-cycle pulses for scan wrap and for a frame-buffer shift
// Optional: define SCAN_BLANK_EN to blank the first cycle of every column's dwell (anti-ghosting).
module scroll_scan_driver #(
    parameter int DISP_COLS     = 8,
    parameter int DWELL         = 1000,
    parameter int SCROLL_FRAMES = 50,
    parameter int MSG_MAX       = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         run,
    input  logic                         wr_en,
    input  logic [$clog2(MSG_MAX)-1:0]   wr_addr,
    input  logic [8:0]                   wr_data,
    input  logic [$clog2(MSG_MAX):0]     msg_len,
    output logic [8:0]                   c,
    input  logic [6:0]                   col_0,
    input  logic [6:0]                   col_1,
    input  logic [6:0]                   col_2,
    input  logic [6:0]                   col_3,
    input  logic [6:0]                   col_4,
    input  logic [6:0]                   col_5,
    output logic [DISP_COLS-1:0]         col_sel_n,
    output logic [6:0]                   row_n,
    output logic                         frame_done,
    output logic                         scroll_step
);

    localparam int AW = $clog2(MSG_MAX);
    localparam int DW = $clog2(DWELL);
    localparam int CW = $clog2(DISP_COLS);
    localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(DISP_COLS - 1);
    localparam logic [FW-1:0] FRM_LAST   = FW'(SCROLL_FRAMES - 1);

    logic [DW-1:0] dwell_cnt;
    logic [CW-1:0] scan_col;
    logic [FW-1:0] frame_cnt;
    logic [AW-1:0] char_idx;
    logic [2:0]    col_idx;
    logic [6:0]    frame [DISP_COLS];
    logic [8:0]    msg   [MSG_MAX];

    logic          dwell_last;
    logic          wrap;
    logic          do_step;
    logic          msg_empty;
    logic          idx_bad;
    logic          char_last;
    logic [6:0]    dec_col;
    logic [6:0]    new_col;

    assign dwell_last = (dwell_cnt == DWELL_LAST);
    assign wrap       = dwell_last && (scan_col == COL_LAST);
    // Shifting only on the scan wrap keeps every displayed frame internally consistent.
    assign do_step    = wrap && (frame_cnt == FRM_LAST) && run;
    assign msg_empty  = (msg_len == '0);
    // Also true when msg_len shrank below the current character (and when msg_len is 0).
    assign idx_bad    = ({1'b0, char_idx} >= msg_len);
    assign char_last  = (({1'b0, char_idx} + (AW+1)'(1)) >= msg_len);

    // The message array is read asynchronously, so a same-cycle write is seen by the step as old data.
    assign c = msg_empty ? 9'd0 : msg[char_idx];

    always_comb begin
        dec_col = 7'h7F;
        case (col_idx)
            3'd0:    dec_col = col_0;
            3'd1:    dec_col = col_1;
            3'd2:    dec_col = col_2;
            3'd3:    dec_col = col_3;
            3'd4:    dec_col = col_4;
            3'd5:    dec_col = col_5;
            default: dec_col = 7'h7F;
        endcase
        new_col = idx_bad ? 7'h7F : dec_col;
    end

    // Scan timing and scroll bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dwell_cnt   <= '0;
            scan_col    <= '0;
            frame_cnt   <= '0;
            char_idx    <= '0;
            col_idx     <= '0;
            frame_done  <= 1'b0;
            scroll_step <= 1'b0;
        end else begin
            frame_done  <= wrap;
            scroll_step <= do_step;
            if (dwell_last) begin
                dwell_cnt <= '0;
                scan_col  <= (scan_col == COL_LAST) ? '0 : scan_col + CW'(1);
            end else begin
                dwell_cnt <= dwell_cnt + DW'(1);
            end
            if (wrap) begin
                frame_cnt <= (frame_cnt == FRM_LAST) ? '0 : frame_cnt + FW'(1);
            end
            if (do_step) begin
                if (idx_bad) begin
                    char_idx <= '0;
                    col_idx  <= '0;
                end else if (col_idx == 3'd5) begin
                    col_idx  <= '0;
                    char_idx <= char_last ? '0 : char_idx + AW'(1);
                end else begin
                    col_idx  <= col_idx + 3'd1;
                end
            end
        end
    end

    // Frame buffer: shifts left, new column enters at the right edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DISP_COLS; i++) frame[i] <= 7'h7F;
        end else if (do_step) begin
            for (int i = 0; i < DISP_COLS - 1; i++) frame[i] <= frame[i+1];
            frame[DISP_COLS-1] <= new_col;
        end
    end

    // Message storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MSG_MAX; i++) msg[i] <= 9'd0;
        end else if (wr_en) begin
            msg[wr_addr] <= wr_data;
        end
    end

    // Matrix drive, one cycle behind the scan position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_sel_n <= '1;
            row_n     <= 7'h7F;
        end else begin
`ifdef SCAN_BLANK_EN
            // First cycle of every dwell is dark so the previous column cannot ghost.
            if (dwell_cnt == '0) begin
                col_sel_n <= '1;
                row_n     <= 7'h7F;
            end else begin
                col_sel_n <= ~(DISP_COLS'(1) << scan_col);
                row_n     <= frame[scan_col];
            end
`else
            col_sel_n <= ~(DISP_COLS'(1) << scan_col);
            row_n     <= frame[scan_col];
`endif
        end
    end

endmodule

// File: tb/tb_scroll_scan_driver.sv
module tb_scroll_scan_driver;

    localparam int COLS = 8;
    localparam int DWL  = 4;
    localparam int SF   = 2;
    localparam int MM   = 16;
    localparam int PER  = COLS * DWL;

    logic       clk = 1'b0;
    logic       reset, run, wr_en;
    logic [3:0] wr_addr;
    logic [8:0] wr_data;
    logic [4:0] msg_len;
    logic [8:0] c;
    logic [6:0] col_0, col_1, col_2, col_3, col_4, col_5;
    logic [7:0] col_sel_n;
    logic [6:0] row_n;
    logic       frame_done, scroll_step;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Stand-in character decoder: 'A' has its real glyph, other codes get distinct column patterns.
    function automatic logic [6:0] font(input logic [8:0] code, input int k);
        int tmp;
        if (k >= 5) return 7'h7F;
        if (code == 9'h041) return (k == 0 || k == 4) ? 7'h01 : 7'h76;
        tmp = (int'(code) * 37 + k * 11 + 3) % 128;
        return tmp[6:0];
    endfunction

    assign col_0 = font(c, 0);
    assign col_1 = font(c, 1);
    assign col_2 = font(c, 2);
    assign col_3 = font(c, 3);
    assign col_4 = font(c, 4);
    assign col_5 = font(c, 5);

    scroll_scan_driver #(
        .DISP_COLS(COLS), .DWELL(DWL), .SCROLL_FRAMES(SF), .MSG_MAX(MM)
    ) dut (
        .clk(clk), .reset(reset), .run(run),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .msg_len(msg_len),
        .c(c),
        .col_0(col_0), .col_1(col_1), .col_2(col_2), .col_3(col_3), .col_4(col_4), .col_5(col_5),
        .col_sel_n(col_sel_n), .row_n(row_n),
        .frame_done(frame_done), .scroll_step(scroll_step)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: time since reset release determines the scan position; scroll state is
    // a plain array plus character/column pointers.
    int         n = 0;
    int         steps = 0;
    int         mchar = 0;
    int         mcol = 0;
    logic [6:0] mframe [COLS];
    logic [8:0] mmsg   [MM];
    logic [7:0] e_sel;
    logic [6:0] e_row;
    logic       e_fd, e_ss;
    logic [8:0] e_c;

    always begin
        int scol, dph;
        logic lit;
        logic [6:0] nc;
        @(posedge clk);
        if (reset) begin
            n = 0; mchar = 0; mcol = 0;
            for (int i = 0; i < COLS; i++) mframe[i] = 7'h7F;
            for (int i = 0; i < MM; i++) mmsg[i] = 9'd0;
            e_sel = 8'hFF; e_row = 7'h7F; e_fd = 1'b0; e_ss = 1'b0;
        end else begin
            n++;
            scol = ((n - 1) / DWL) % COLS;
            dph  = (n - 1) % DWL;
`ifdef SCAN_BLANK_EN
            lit = (dph != 0);
`else
            lit = 1'b1;
`endif
            e_sel = lit ? ~(8'h01 << scol) : 8'hFF;
            e_row = lit ? mframe[scol] : 7'h7F;
            e_fd  = (n % PER == 0);
            e_ss  = e_fd && ((n / PER) % SF == 0) && run;
            if (e_ss) begin
                if (msg_len == 0 || mchar >= int'(msg_len)) begin
                    nc = 7'h7F; mchar = 0; mcol = 0;
                end else begin
                    nc = font(mmsg[mchar], mcol);
                    if (mcol == 5) begin
                        mcol  = 0;
                        mchar = (mchar + 1 >= int'(msg_len)) ? 0 : mchar + 1;
                    end else begin
                        mcol++;
                    end
                end
                for (int i = 0; i < COLS - 1; i++) mframe[i] = mframe[i+1];
                mframe[COLS-1] = nc;
                steps++;
            end
            if (wr_en) mmsg[wr_addr] = wr_data;
        end
        e_c = (msg_len == 0) ? 9'd0 : mmsg[mchar];
        #1;
        check("col_sel_n", 32'(col_sel_n), 32'(e_sel));
        check("row_n", 32'(row_n), 32'(e_row));
        check("frame_done", 32'(frame_done), 32'(e_fd));
        check("scroll_step", 32'(scroll_step), 32'(e_ss));
        if (!reset) check("c", 32'(c), 32'(e_c));
    end

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_sel", 32'(col_sel_n), 32'h0FF);
        check("rst_row", 32'(row_n), 32'h07F);
        check("rst_fd", 32'(frame_done), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic write_msg(input logic [3:0] a, input logic [8:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_steps(input int k);
        int target;
        target = steps + k;
        for (int i = 0; i < 200 * PER && steps < target; i++) @(negedge clk);
        if (steps < target) begin
            bad++;
            total++;
            $display("FAIL wait_steps: got %0d steps expected %0d", steps, target);
        end
    endtask

    initial begin
        int cnt;
        reset = 1'b1; run = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; msg_len = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #2;
`ifndef SCAN_BLANK_EN
        check("first_lit_sel", 32'(col_sel_n), 32'h0FE);
`endif
        check("first_lit_row", 32'(row_n), 32'h07F);

        // Idle scan: exactly 3 frame_done pulses in any 96-cycle window.
        @(negedge clk);
        cnt = 0;
        for (int i = 0; i < 3 * PER; i++) begin
            @(negedge clk);
            if (frame_done) cnt++;
        end
        check("idle_fd_count", 32'(cnt), 32'd3);

        // Scroll "A".
        do_reset();
        write_msg(4'd0, 9'h041);
        msg_len = 5'd1; run = 1'b1;
        wait_steps(1);
        check("A_step1_f7", 32'(mframe[7]), 32'h01);
        wait_steps(4);
        check("A_f3", 32'(mframe[3]), 32'h01);
        check("A_f4", 32'(mframe[4]), 32'h76);
        check("A_f5", 32'(mframe[5]), 32'h76);
        check("A_f6", 32'(mframe[6]), 32'h76);
        check("A_f7", 32'(mframe[7]), 32'h01);
        wait_steps(1);
        check("A_gap", 32'(mframe[7]), 32'h7F);
        wait_steps(1);
        check("A_repeat", 32'(mframe[7]), 32'h01);

        // "KE" with a freeze.
        do_reset();
        write_msg(4'd0, 9'h04B);
        write_msg(4'd1, 9'h045);
        msg_len = 5'd2; run = 1'b1;
        wait_steps(2);
        @(negedge clk);
        run = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3 * PER; i++) begin
            @(negedge clk);
            if (scroll_step) cnt++;
        end
        check("freeze_steps", 32'(cnt), 32'd0);
        run = 1'b1;
        wait_steps(10);
        check("KE_wrap_char", 32'(mchar), 32'd0);
        check("KE_wrap_col", 32'(mcol), 32'd0);

        // Shrink while on the second character, then empty message.
        wait_steps(7);
        check("shrink_pre_char", 32'(mchar), 32'd1);
        msg_len = 5'd1;
        wait_steps(1);
        check("shrink_blank", 32'(mframe[7]), 32'h7F);
        wait_steps(1);
        check("shrink_restart", 32'(mframe[7]), 32'(font(9'h04B, 0)));
        @(negedge clk);
        msg_len = 5'd0;
        #1;
        check("empty_c", 32'(c), 32'h0);
        wait_steps(3);
        check("empty_col", 32'(mframe[7]), 32'h7F);

        // Randomized traffic with a mid-run reset.
        msg_len = 5'd3;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            wr_en   = ($urandom % 6 == 0);
            wr_addr = 4'($urandom);
            wr_data = 9'($urandom);
            if ($urandom % 150 == 0) msg_len = 5'($urandom_range(0, 16));
            if ($urandom % 100 == 0) run = ($urandom % 4 != 0);
            if (i == 3000) begin
                wr_en = 1'b0;
                do_reset();
            end
        end
        @(negedge clk);
        wr_en = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
